des_key_sched: RTL and testbench

Triple-DES subkey scheduler for the ECCDH3DES datapath. It takes the 192-bit session key bundle produced from the ECC shared point and expands it into the 48 round subkeys (3 DES stages × 16 rounds) that the DES round engine consumes. Subkeys are generated one per cycle and stored in a 48-entry table in execution order, so the round engine reads them with a single round index. The schedule completes inside the controller's 48-cycle initialisation window.

---
 rtl/des_key_sched_if.sv | 23 ++
 rtl/des_key_sched.sv | 180 ++++++++++++++++++
 tb/tb_des_key_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/des_key_sched_if.sv
// Request/read bundle between the 3DES controller and the subkey scheduler.
interface des_key_sched_if #(
  parameter int unsigned SKW = 48
);
  logic           load;
  logic [191:0]   keys;
  logic           is_encrypt;
  logic [5:0]     rd_idx;
  logic [SKW-1:0] rd_key;
  logic           busy;
  logic           ready;
  logic           parity_err;

  modport master (
    output load, keys, is_encrypt, rd_idx,
    input  rd_key, busy, ready, parity_err
  );

  modport slave (
    input  load, keys, is_encrypt, rd_idx,
    output rd_key, busy, ready, parity_err
  );
endinterface

// File: rtl/des_key_sched.sv
// Triple-DES subkey scheduler: expands K1/K2/K3 into 48 round subkeys, one per cycle,
// stored in execution order. Optional key byte parity check: KEY_PARITY_CHECK_EN.
module des_key_sched #(
  parameter int unsigned NSUB = 48,
  parameter int unsigned SKW  = 48
) (
  input logic            clk,
  input logic            n_rst,
  des_key_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GEN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bit r set means round r rotates by one; all other rounds rotate by two.
  localparam logic [15:0] ONE_SHIFT = 16'b1000_0001_0000_0011;

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Table positions are 1-based from the MSB, as in FIPS 46-3.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      r[55-i] = k[6'(64 - PC1_T[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      r[47-i] = cd[6'(56 - PC2_T[i])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  logic [1:0]     state_q, state_d;
  logic [3:0]     round_q, round_d;
  logic [1:0]     stage_q, stage_d;
  logic [191:0]   keys_q, keys_d;
  logic           enc_q, enc_d;
  logic [27:0]    c_q, c_d;
  logic [27:0]    d_q, d_d;
  logic [SKW-1:0] table_q [NSUB];

  logic           rev;
  logic [63:0]    stage_key;
  logic [55:0]    cd_init;
  logic [27:0]    c_src, d_src, c_rot, d_rot;
  logic [47:0]    subkey;
  logic [5:0]     waddr;
  logic           gen_we;

  always_comb begin
    rev       = enc_q ? (stage_q == 2'd1) : (stage_q != 2'd1);
    stage_key = keys_q[127:64];
    if (stage_q == 2'd0) begin
      stage_key = enc_q ? keys_q[63:0] : keys_q[191:128];
    end else if (stage_q == 2'd2) begin
      stage_key = enc_q ? keys_q[191:128] : keys_q[63:0];
    end
    cd_init = pc1(stage_key);
    c_src   = (round_q == 4'd0) ? cd_init[55:28] : c_q;
    d_src   = (round_q == 4'd0) ? cd_init[27:0]  : d_q;
    c_rot   = rotl28(c_src, ONE_SHIFT[round_q]);
    d_rot   = rotl28(d_src, ONE_SHIFT[round_q]);
    subkey  = pc2({c_rot, d_rot});
    // Reverse stages fill their 16-entry block from the top: 15-round == ~round.
    waddr   = {stage_q, rev ? ~round_q : round_q};
    gen_we  = (state_q == GEN) && !bus.load;
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    stage_d = stage_q;
    keys_d  = keys_q;
    enc_d   = enc_q;
    c_d     = c_q;
    d_d     = d_q;
    if (bus.load) begin
      state_d = GEN;
      round_d = '0;
      stage_d = '0;
      keys_d  = bus.keys;
      enc_d   = bus.is_encrypt;
    end else if (state_q == GEN) begin
      c_d     = c_rot;
      d_d     = d_rot;
      round_d = round_q + 4'd1;
      if (round_q == 4'd15) begin
        if (stage_q == 2'd2) begin
          state_d = DONE;
        end else begin
          stage_d = stage_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      round_q <= '0;
      stage_q <= '0;
      keys_q  <= '0;
      enc_q   <= 1'b0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      stage_q <= stage_d;
      keys_q  <= keys_d;
      enc_q   <= enc_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < NSUB; i++) begin
        table_q[i] <= '0;
      end
    end else if (gen_we) begin
      table_q[waddr] <= subkey;
    end
  end

  assign bus.rd_key = (32'(bus.rd_idx) < NSUB) ? table_q[bus.rd_idx] : '0;
  assign bus.busy   = (state_q == GEN);
  assign bus.ready  = (state_q == DONE);

`ifdef KEY_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;

  // DES keys carry odd parity per byte; any even-parity byte flags the bundle.
  always_comb begin
    parity_err_d = 1'b0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (!(^bus.keys[i*8 +: 8])) begin
        parity_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_err_q <= 1'b0;
    end else if (bus.load) begin
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: stimulus queues expectations, a negedge monitor checks them.
module tb_des_key_sched;

  localparam int K_RD   = 0;
  localparam int K_BUSY = 1;
  localparam int K_RDY  = 2;
  localparam int K_PAR  = 3;

  localparam logic [63:0] KAT  = 64'h133457799BBCDFF1;
  localparam logic [63:0] K01  = 64'h0101010101010101;
  localparam logic [63:0] KFE  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [47:0] SK1  = 48'h1B02EFFC7072;
  localparam logic [47:0] SK2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] SK3  = 48'h55FC8A42CF99;
  localparam logic [47:0] SK16 = 48'hCB3D8B0E17F5;
  localparam logic [47:0] ONES = 48'hFFFFFFFFFFFF;

`ifdef KEY_PARITY_CHECK_EN
  localparam logic [47:0] PAR_ZERO_EXP = 48'd1;
`else
  localparam logic [47:0] PAR_ZERO_EXP = 48'd0;
`endif

  typedef struct {
    int          kind;
    logic [47:0] exp;
    string       name;
  } item_t;

  logic  clk = 1'b0;
  logic  n_rst = 1'b0;
  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  des_key_sched_if #(.SKW(48)) bus ();

  des_key_sched #(.NSUB(48), .SKW(48)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Monitor: every queued expectation is compared at the next falling edge.
  initial begin
    item_t       it;
    logic [47:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        case (it.kind)
          K_RD:    act = bus.rd_key;
          K_BUSY:  act = {47'd0, bus.busy};
          K_RDY:   act = {47'd0, bus.ready};
          default: act = {47'd0, bus.parity_err};
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.busy && bus.ready) begin
      errors++;
      $display("FAIL busy_ready_excl: busy=%b ready=%b expected not both 1", bus.busy, bus.ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int kind, input logic [47:0] v, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = v;
    it.name = name;
    exp_q.push_back(it);
  endtask

  task automatic rd(input int idx, input logic [47:0] v, input string name);
    bus.rd_idx = 6'(idx);
    expect_sig(K_RD, v, $sformatf("%s[%0d]", name, idx));
    tick();
  endtask

  // Returns one cycle after the sampling edge E0.
  task automatic do_load(input logic [191:0] k, input logic enc);
    bus.keys       = k;
    bus.is_encrypt = enc;
    bus.load       = 1'b1;
    tick();
    bus.load       = 1'b0;
  endtask

  // Called at E0+1: ready must stay low through E47 and rise at E48.
  task automatic finish_gen(input string name);
    expect_sig(K_BUSY, 48'd1, {name, "_busy_start"});
    expect_sig(K_RDY,  48'd0, {name, "_ready_start"});
    repeat (47) tick();
    expect_sig(K_RDY,  48'd0, {name, "_ready_e47"});
    tick();
    expect_sig(K_RDY,  48'd1, {name, "_ready_e48"});
    expect_sig(K_BUSY, 48'd0, {name, "_busy_e48"});
    tick();
  endtask

  initial begin
    bus.load       = 1'b0;
    bus.keys       = '0;
    bus.is_encrypt = 1'b0;
    bus.rd_idx     = '0;

    // Reset state
    tick();
    expect_sig(K_BUSY, 48'd0, "rst_busy");
    expect_sig(K_RDY,  48'd0, "rst_ready");
    expect_sig(K_PAR,  48'd0, "rst_parity");
    rd(0, 48'd0, "rst_tab");
    rd(47, 48'd0, "rst_tab");
    n_rst = 1'b1;
    tick();

    // Encrypt KAT, same key in all three stages
    do_load({3{KAT}}, 1'b1);
    expect_sig(K_PAR, 48'd0, "kat_parity");
    finish_gen("kat");
    rd(0, SK1, "enc");
    rd(1, SK2, "enc");
    rd(2, SK3, "enc");
    rd(15, SK16, "enc");
    rd(16, SK16, "enc");
    rd(30, SK2, "enc");
    rd(31, SK1, "enc");
    rd(32, SK1, "enc");
    rd(33, SK2, "enc");
    rd(47, SK16, "enc");
    rd(48, 48'd0, "oob");
    rd(63, 48'd0, "oob");

    // Decrypt order: K3 rev, K2 fwd, K1 rev
    do_load({K01, K01, KAT}, 1'b0);
    finish_gen("dec");
    rd(0, 48'd0, "dec");
    rd(15, 48'd0, "dec");
    rd(16, 48'd0, "dec");
    rd(31, 48'd0, "dec");
    rd(32, SK16, "dec");
    rd(46, SK2, "dec");
    rd(47, SK1, "dec");

    // Restart: second load sampled at E20 replaces the first
    do_load({3{KAT}}, 1'b1);
    repeat (19) tick();
    do_load({3{KFE}}, 1'b1);
    finish_gen("restart");
    for (int i = 0; i < 48; i++) rd(i, ONES, "restart");

    // Load from DONE with all-zero keys: parity flag, ready drops, stale table
    bus.rd_idx = 6'd5;
    do_load(192'd0, 1'b1);
    expect_sig(K_PAR, PAR_ZERO_EXP, "par_zero");
    expect_sig(K_RD, ONES, "stale_tab[5]");
    finish_gen("zero");
    expect_sig(K_PAR, PAR_ZERO_EXP, "par_zero_held");
    rd(0, 48'd0, "zero");
    rd(5, 48'd0, "zero");

    // Good-parity keys, then reset at E10 mid-generation
    do_load({3{KAT}}, 1'b1);
    expect_sig(K_PAR, 48'd0, "par_good");
    repeat (10) tick();
    n_rst = 1'b0;
    expect_sig(K_BUSY, 48'd0, "midrst_busy");
    expect_sig(K_RDY,  48'd0, "midrst_ready");
    expect_sig(K_PAR,  48'd0, "midrst_parity");
    for (int i = 0; i < 64; i++) rd(i, 48'd0, "midrst");
    n_rst = 1'b1;
    tick();

    // Mixed keys after reset: K1=0101.., K2=KAT, K3=FEFE.., encrypt
    do_load({KFE, KAT, K01}, 1'b1);
    finish_gen("mixed");
    rd(0, 48'd0, "mixed");
    rd(15, 48'd0, "mixed");
    rd(16, SK16, "mixed");
    rd(30, SK2, "mixed");
    rd(31, SK1, "mixed");
    rd(32, ONES, "mixed");
    rd(47, ONES, "mixed");

    for (int t = 0; t < 8 && exp_q.size() != 0; t++) tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
